// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared array defaults, control state encoding and flat-matrix indexing
package sa_pkg;

   localparam int SA_W = 16;
   localparam int SA_N = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_DRAIN = 2'd2
   } sa_state_t;

   // Element slot of (r,c) in a flat N*N matrix; (0,0) lives in the top slot.
   function automatic int elem_idx(input int r, input int c, input int n);
      return n * n - 1 - (r * n + c);
   endfunction

endpackage

// File: rtl/feeder_lane_sel.sv
// rtl/feeder_lane_sel.sv - picks the skewed element for one lane at step k, or zero
module feeder_lane_sel
   import sa_pkg::*;
#(
   parameter int W    = SA_W,
   parameter int N    = SA_N,
   parameter int KW   = 3,
   parameter int LANE = 0,
   parameter bit IS_B = 1'b0
) (
   input  logic               active,
   input  logic [KW-1:0]      k,
   input  logic [W*N*N-1:0]   mat,
   output logic [W-1:0]       elem
);

   // A lanes walk along row LANE, B lanes walk down column LANE, both delayed by LANE steps
   always_comb begin
      int d;
      int idx;
      elem = '0;
      d    = int'(k) - LANE;
      idx  = 0;
      if (active && d >= 0 && d < N) begin
         if (IS_B) idx = elem_idx(d, LANE, N);
         else      idx = elem_idx(LANE, d, N);
         elem = mat[idx*W +: W];
      end
   end

endmodule

// File: rtl/matrix_skew_feeder.sv
// rtl/matrix_skew_feeder.sv - skews a captured A/B matrix pair into systolic row/column lanes (debug ports: FEEDER_DEBUG_EN)
module matrix_skew_feeder
   import sa_pkg::*;
#(
   parameter int W = SA_W,
   parameter int N = SA_N
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_en,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic [W*N*N-1:0]           i_A,
   input  logic [W*N*N-1:0]           i_B,
   output logic [W*N-1:0]             o_a,
   output logic [W*N-1:0]             o_b,
   output logic                       o_valid,
   output logic                       o_done
`ifdef FEEDER_DEBUG_EN
   ,
   output logic [1:0]                 o_d_state,
   output logic [$clog2(2*N)-1:0]     o_d_k
`endif
);

   localparam int            KW          = $clog2(2*N);
   localparam logic [KW-1:0] K_FEED_LAST  = KW'(2*N-2);
   localparam logic [KW-1:0] K_DRAIN_LAST = KW'(N-1);

   sa_state_t            state;
   logic [KW-1:0]        k;
   logic [W*N*N-1:0]     a_q;
   logic [W*N*N-1:0]     b_q;
   logic                 feed;

   assign feed    = (state == ST_FEED);
   assign o_ready = (state == ST_IDLE);
   assign o_valid = feed && i_en;

   // Sequencer: capture a pair, step through 2N-1 feed beats, then N drain beats
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state  <= ST_IDLE;
         k      <= '0;
         a_q    <= '0;
         b_q    <= '0;
         o_done <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_valid) begin
                  a_q   <= i_A;
                  b_q   <= i_B;
                  k     <= '0;
                  state <= ST_FEED;
               end
            end
            ST_FEED: begin
               if (i_en) begin
                  if (k == K_FEED_LAST) begin
                     k     <= '0;
                     state <= ST_DRAIN;
                  end else begin
                     k <= k + 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (i_en) begin
                  if (k == K_DRAIN_LAST) begin
                     k      <= '0;
                     state  <= ST_IDLE;
                     o_done <= 1'b1;
                  end else begin
                     k <= k + 1'b1;
                  end
               end
            end
            default: begin
               k     <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // One selector per row lane of A and per column lane of B
   for (genvar i = 0; i < N; i++) begin : g_lane
      feeder_lane_sel #(
         .W(W), .N(N), .KW(KW), .LANE(i), .IS_B(1'b0)
      ) u_a_sel (
         .active(feed),
         .k     (k),
         .mat   (a_q),
         .elem  (o_a[W*i +: W])
      );
      feeder_lane_sel #(
         .W(W), .N(N), .KW(KW), .LANE(i), .IS_B(1'b1)
      ) u_b_sel (
         .active(feed),
         .k     (k),
         .mat   (b_q),
         .elem  (o_b[W*i +: W])
      );
   end

`ifdef FEEDER_DEBUG_EN
   assign o_d_state = state;
   assign o_d_k     = k;
`endif

endmodule

// File: tb/tb_matrix_skew_feeder.sv
// tb/tb_matrix_skew_feeder.sv - scoreboard bench for matrix_skew_feeder against a lane-skew reference model
module tb_matrix_skew_feeder;

   localparam int W  = 16;
   localparam int N  = 3;
   localparam int FW = W*N*N;
   localparam int LW = W*N;

   typedef logic [W-1:0] mat_t [N][N];

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_en;
   logic          i_valid;
   logic          o_ready;
   logic [FW-1:0] i_A;
   logic [FW-1:0] i_B;
   logic [LW-1:0] o_a;
   logic [LW-1:0] o_b;
   logic          o_valid;
   logic          o_done;
`ifdef FEEDER_DEBUG_EN
   logic [1:0]              d_state;
   logic [$clog2(2*N)-1:0]  d_k;
`endif

   int n_tot  = 0;
   int n_pass = 0;
   int beat_cnt = 0;
   int beats0 = 0;
   logic [2*LW-1:0] exp_q[$];
   mat_t cur_a, cur_b;

   matrix_skew_feeder #(.W(W), .N(N)) dut (
      .i_clk  (clk),
      .i_rst  (rst_n),
      .i_en   (i_en),
      .i_valid(i_valid),
      .o_ready(o_ready),
      .i_A    (i_A),
      .i_B    (i_B),
      .o_a    (o_a),
      .o_b    (o_b),
      .o_valid(o_valid),
      .o_done (o_done)
`ifdef FEEDER_DEBUG_EN
      ,
      .o_d_state(d_state),
      .o_d_k    (d_k)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [2*LW-1:0] act, input logic [2*LW-1:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   function automatic logic [FW-1:0] pack_mat(input mat_t m);
      logic [FW-1:0] f;
      f = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            f[W*(N*N-1-(r*N+c)) +: W] = m[r][c];
      return f;
   endfunction

   // Beat k of a systolic feed: row lane i carries A[i][k-i], column lane j carries B[k-j][j]
   function automatic logic [2*LW-1:0] model_beat(input mat_t a, input mat_t b, input int k);
      logic [LW-1:0] ea, eb;
      ea = '0;
      eb = '0;
      for (int i = 0; i < N; i++) begin
         if (k - i >= 0 && k - i < N) begin
            ea[W*i +: W] = a[i][k-i];
            eb[W*i +: W] = b[k-i][i];
         end
      end
      return {ea, eb};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_mats(output mat_t a, output mat_t b);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            a[r][c] = W'($urandom);
            b[r][c] = W'($urandom);
         end
   endtask

   // Offer a pair with i_en high and take it on the next edge
   task automatic present(input mat_t a, input mat_t b);
      cur_a   = a;
      cur_b   = b;
      i_A     = pack_mat(a);
      i_B     = pack_mat(b);
      i_valid = 1'b1;
      i_en    = 1'b1;
      check("ready_before_accept", 2*LW'(o_ready), 2*LW'(1));
      for (int k = 0; k < 2*N-1; k++) exp_q.push_back(model_beat(a, b, k));
      beats0 = beat_cnt;
      tick();
      i_valid = 1'b0;
   endtask

   // Run until o_done (bounded); exp_cycles < 0 skips the cycle-count check
   task automatic finish_pair(input bit rand_en, input int exp_cycles);
      int  cycles;
      bit  got;
      cycles = 0;
      got    = 1'b0;
      while (!got && cycles < 200) begin
         i_en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         cycles++;
         if (o_done) got = 1'b1;
      end
      i_en = 1'b1;
      check("done_seen", 2*LW'(got), 2*LW'(1));
      check("valid_beats", 2*LW'(beat_cnt - beats0), 2*LW'(2*N-1));
      if (exp_cycles >= 0) check("done_latency", 2*LW'(cycles), 2*LW'(exp_cycles));
   endtask

   // Monitor: every valid beat must match the next expected beat from the model
   initial begin
      logic [2*LW-1:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && o_valid) begin
            beat_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 2*LW'(1), 2*LW'(0));
            end else begin
               e = exp_q.pop_front();
               check("beat", {o_a, o_b}, e);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      mat_t a, b;
      rst_n   = 1'b0;
      i_en    = 1'b0;
      i_valid = 1'b0;
      i_A     = '0;
      i_B     = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Reset state
      check("rst_ready", 2*LW'(o_ready), 2*LW'(1));
      check("rst_valid", 2*LW'(o_valid), 2*LW'(0));
      check("rst_done", 2*LW'(o_done), 2*LW'(0));
      check("rst_lanes", {o_a, o_b}, '0);

      // Column 2 of ones in both matrices
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            a[r][c] = (c == 2) ? 16'h3c00 : 16'h0000;
            b[r][c] = (c == 2) ? 16'h3c00 : 16'h0000;
         end
      present(a, b);
      finish_pair(1'b0, 3*N-1);

      // Indexed A: lane skew at k=2 is {A20, A11, A02}
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) a[r][c] = W'(16*r + c);
      rand_mats(cur_a, b);
      present(a, b);
      tick();
      tick();
      check("k2_lanes_a", 2*LW'(o_a), 2*LW'(48'h0020_0011_0002));
      finish_pair(1'b0, 3*N-1-2);

      // Freeze at k=1 for 4 cycles
      rand_mats(a, b);
      present(a, b);
      tick();
      i_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("freeze_valid", 2*LW'(o_valid), 2*LW'(0));
         check("freeze_lanes", {o_a, o_b}, model_beat(cur_a, cur_b, 1));
      end
      i_en = 1'b1;
      finish_pair(1'b0, 3*N-1-1);

      // i_valid with other data mid-feed is ignored
      rand_mats(a, b);
      present(a, b);
      tick();
      tick();
      i_A     = ~pack_mat(a);
      i_B     = ~pack_mat(b);
      i_valid = 1'b1;
      #1;
      check("busy_not_ready", 2*LW'(o_ready), 2*LW'(0));
      tick();
      i_valid = 1'b0;
      finish_pair(1'b0, 3*N-1-3);

      // Reset asserted at k=3
      rand_mats(a, b);
      present(a, b);
      tick();
      tick();
      tick();
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_lanes", {o_a, o_b}, '0);
      check("midrst_valid", 2*LW'(o_valid), 2*LW'(0));
      check("midrst_done", 2*LW'(o_done), 2*LW'(0));
      check("midrst_ready", 2*LW'(o_ready), 2*LW'(1));
      check("midrst_pending", 2*LW'(exp_q.size()), 2*LW'(2));
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      tick();
      check("postrst_ready", 2*LW'(o_ready), 2*LW'(1));
      for (int i = 0; i < 4; i++) begin
         tick();
         check("postrst_no_done", 2*LW'(o_done), 2*LW'(0));
      end

      // Back-to-back: next pair accepted while o_done is high
      rand_mats(a, b);
      present(a, b);
      finish_pair(1'b0, 3*N-1);
      check("b2b_done", 2*LW'(o_done), 2*LW'(1));
      rand_mats(a, b);
      present(a, b);
      check("b2b_feed_valid", 2*LW'(o_valid), 2*LW'(1));
      check("b2b_done_clear", 2*LW'(o_done), 2*LW'(0));
      finish_pair(1'b0, 3*N-1-0);

      // Random pairs with random enable
      for (int t = 0; t < 6; t++) begin
         rand_mats(a, b);
         present(a, b);
         finish_pair(1'b1, -1);
      end

      tick();
      check("queue_empty", 2*LW'(exp_q.size()), 2*LW'(0));
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
